// File: rtl/icc_branch_ctrl.sv
// ---------------------------------------------------------------------------
// icc_branch_ctrl
//
// Holds the integer condition codes {N,Z,V,C} written by the ALU on
// cc-setting ops. Evaluates Bicc conditions against them, registers the
// branch-taken decision and target PC, and flags the delay slot for
// annulment.
//
// Ports
//   Clk        : clock, all state updates on the rising edge
//   Clr        : synchronous active-low reset, overrides everything
//   stall      : pipeline stall, holds all state and outputs
//   icc_we     : write N_in..C_in into icc this cycle
//   N_in..C_in : ALU flag outputs
//   br_valid   : a Bicc instruction is presented this cycle
//   cond       : Bicc cond field
//   a          : annul bit
//   br_target  : computed branch target
//   icc_out    : registered {N,Z,V,C}
//   Cout       : icc carry, fed back to the ALU carry-in (ADDX/SUBX)
//   br_taken   : registered taken decision (one-cycle pulse unless stalled)
//   pc_target  : registered target, meaningful while br_taken=1
//   squash     : delay-slot instruction must be annulled
// ---------------------------------------------------------------------------
module icc_branch_ctrl #(
    parameter int AW = 32
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          stall,
    input  logic          icc_we,
    input  logic          N_in,
    input  logic          Z_in,
    input  logic          V_in,
    input  logic          C_in,
    input  logic          br_valid,
    input  logic [3:0]    cond,
    input  logic          a,
    input  logic [AW-1:0] br_target,
    output logic [3:0]    icc_out,
    output logic          Cout,
    output logic          br_taken,
    output logic [AW-1:0] pc_target,
    output logic          squash
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DLY_EXEC  = 2'd1;
    localparam logic [1:0] DLY_ANNUL = 2'd2;

    logic [1:0]    state_reg;
    logic [3:0]    icc_reg;
    logic          br_taken_reg;
    logic          squash_reg;
    logic [AW-1:0] pc_target_reg;

    logic [3:0]    flags_in;
    logic [3:0]    eval_flags;
    logic          base_true;
    logic          taken;
    logic          squash_next;
    logic          accept;

    assign flags_in = {N_in, Z_in, V_in, C_in};

    // A branch issued alongside a cc-setting op must see the new flags.
    assign eval_flags = icc_we ? flags_in : icc_reg;

    // cond[2:0] selects the base test; cond[3] inverts it. This yields
    // never/always for 0000/1000 and the complemented set for 1001..1111.
    always_comb begin
        base_true = 1'b0;
        case (cond[2:0])
            3'd0: base_true = 1'b0;
            3'd1: base_true = eval_flags[2];
            3'd2: base_true = eval_flags[2] | (eval_flags[3] ^ eval_flags[1]);
            3'd3: base_true = eval_flags[3] ^ eval_flags[1];
            3'd4: base_true = eval_flags[0] | eval_flags[2];
            3'd5: base_true = eval_flags[0];
            3'd6: base_true = eval_flags[3];
            3'd7: base_true = eval_flags[1];
            default: base_true = 1'b0;
        endcase
    end

    assign taken       = cond[3] ^ base_true;
    // BA,a annuls its delay slot even though taken; other taken branches
    // with a=1 execute it.
    assign squash_next = a & (~taken | (cond == 4'b1000));
    // The instruction after an annulling branch is the squashed slot, so a
    // branch seen in DLY_ANNUL is not accepted.
    assign accept      = br_valid & ~stall & (state_reg != DLY_ANNUL);

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_reg     <= IDLE;
            icc_reg       <= 4'b0000;
            br_taken_reg  <= 1'b0;
            squash_reg    <= 1'b0;
            pc_target_reg <= '0;
        end else if (!stall) begin
            if (icc_we) begin
                icc_reg <= flags_in;
            end
            if (accept) begin
                br_taken_reg <= taken;
                squash_reg   <= squash_next;
                state_reg    <= squash_next ? DLY_ANNUL : DLY_EXEC;
                if (taken) begin
                    pc_target_reg <= br_target;
                end
            end else begin
                br_taken_reg <= 1'b0;
                squash_reg   <= 1'b0;
                state_reg    <= IDLE;
            end
        end
    end

    assign icc_out   = icc_reg;
    assign Cout      = icc_reg[0];
    assign br_taken  = br_taken_reg;
    assign squash    = squash_reg;
    assign pc_target = pc_target_reg;

endmodule

// File: tb/tb_icc_branch_ctrl.sv
module tb_icc_branch_ctrl;

    localparam int AW = 32;

    logic          Clk = 1'b0;
    logic          Clr;
    logic          stall;
    logic          icc_we;
    logic          N_in, Z_in, V_in, C_in;
    logic          br_valid;
    logic [3:0]    cond;
    logic          a;
    logic [AW-1:0] br_target;
    logic [3:0]    icc_out;
    logic          Cout;
    logic          br_taken;
    logic [AW-1:0] pc_target;
    logic          squash;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: architectural view of what the outputs should be.
    logic [3:0]    m_icc;
    logic          m_taken;
    logic          m_squash;
    logic [AW-1:0] m_pc;

    icc_branch_ctrl #(.AW(AW)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .stall     (stall),
        .icc_we    (icc_we),
        .N_in      (N_in),
        .Z_in      (Z_in),
        .V_in      (V_in),
        .C_in      (C_in),
        .br_valid  (br_valid),
        .cond      (cond),
        .a         (a),
        .br_target (br_target),
        .icc_out   (icc_out),
        .Cout      (Cout),
        .br_taken  (br_taken),
        .pc_target (pc_target),
        .squash    (squash)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, tag, got, exp);
        end
    endtask

    // Bicc truth table written out for all 16 codes.
    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'b0000: return 1'b0;
            4'b0001: return z;
            4'b0010: return z | (n ^ v);
            4'b0011: return n ^ v;
            4'b0100: return cy | z;
            4'b0101: return cy;
            4'b0110: return n;
            4'b0111: return v;
            4'b1000: return 1'b1;
            4'b1001: return !z;
            4'b1010: return !(z | (n ^ v));
            4'b1011: return !(n ^ v);
            4'b1100: return !(cy | z);
            4'b1101: return !cy;
            4'b1110: return !n;
            default: return !v;
        endcase
    endfunction

    // Advance the model with the current inputs, clock once, compare.
    task automatic step();
        logic [3:0] f;
        bit tk, sq, acc;
        f = icc_we ? {N_in, Z_in, V_in, C_in} : m_icc;
        if (!Clr) begin
            m_icc = 4'b0; m_taken = 1'b0; m_squash = 1'b0; m_pc = '0;
        end else if (!stall) begin
            // While a squash is showing, the presented instruction is the annulled slot.
            acc = br_valid && !m_squash;
            tk  = cond_true(cond, f);
            sq  = a && (!tk || cond == 4'b1000);
            if (acc) begin
                m_taken  = tk;
                m_squash = sq;
                if (tk) m_pc = br_target;
            end else begin
                m_taken  = 1'b0;
                m_squash = 1'b0;
            end
            if (icc_we) m_icc = {N_in, Z_in, V_in, C_in};
        end
        @(posedge Clk);
        #1;
        cyc++;
        chk("icc_out",   64'(icc_out),   64'(m_icc));
        chk("Cout",      64'(Cout),      64'(m_icc[0]));
        chk("br_taken",  64'(br_taken),  64'(m_taken));
        chk("squash",    64'(squash),    64'(m_squash));
        chk("pc_target", 64'(pc_target), 64'(m_pc));
    endtask

    task automatic randomize_inputs();
        icc_we    = 1'($urandom);
        {N_in, Z_in, V_in, C_in} = 4'($urandom);
        br_valid  = 1'($urandom);
        cond      = 4'($urandom);
        a         = 1'($urandom);
        br_target = $urandom;
    endtask

    task automatic quiet();
        stall = 1'b0; icc_we = 1'b0; br_valid = 1'b0; a = 1'b0; cond = 4'b0;
    endtask

    task automatic branch(input logic [3:0] c, input logic an, input logic [AW-1:0] t);
        br_valid = 1'b1; cond = c; a = an; br_target = t;
    endtask

    task automatic set_flags(input logic [3:0] f);
        icc_we = 1'b1; {N_in, Z_in, V_in, C_in} = f;
    endtask

    initial begin
        m_icc = 4'b0; m_taken = 1'b0; m_squash = 1'b0; m_pc = '0;
        Clr = 1'b0; stall = 1'b0;
        randomize_inputs();

        // Reset with random activity on every other input
        step();
        randomize_inputs(); stall = 1'($urandom);
        step();
        chk("rst_icc", 64'(icc_out), 64'h0);
        chk("rst_cout", 64'(Cout), 64'h0);
        chk("rst_taken", 64'(br_taken), 64'h0);
        chk("rst_squash", 64'(squash), 64'h0);
        chk("rst_pc", 64'(pc_target), 64'h0);
        $display("reset: icc=%b taken=%b squash=%b pc=%0h", icc_out, br_taken, squash, pc_target);

        // BE after Z is set
        Clr = 1'b1; quiet();
        set_flags(4'b0100); step();
        quiet(); branch(4'b0001, 1'b0, 32'h100); step();
        chk("be_taken", 64'(br_taken), 64'h1);
        chk("be_pc", 64'(pc_target), 64'h100);
        chk("be_squash", 64'(squash), 64'h0);
        $display("BE: taken=%b pc=%0h squash=%b", br_taken, pc_target, squash);
        quiet(); step();
        chk("be_pulse", 64'(br_taken), 64'h0);

        // BNE with same-cycle flag write clearing Z (bypass)
        set_flags(4'b0000); branch(4'b1001, 1'b0, 32'h140); step();
        chk("bne_bypass", 64'(br_taken), 64'h1);
        $display("BNE bypass: taken=%b pc=%0h", br_taken, pc_target);
        quiet(); step();

        // BLE,a not taken -> squash, following BA ignored
        set_flags(4'b1010); step();
        quiet(); branch(4'b0010, 1'b1, 32'h180); step();
        chk("ble_taken", 64'(br_taken), 64'h0);
        chk("ble_squash", 64'(squash), 64'h1);
        quiet(); branch(4'b1000, 1'b0, 32'h300); step();
        chk("annul_ign_taken", 64'(br_taken), 64'h0);
        chk("annul_ign_squash", 64'(squash), 64'h0);
        $display("BLE,a: squashed slot BA ignored taken=%b", br_taken);

        // BA,a and BN
        quiet(); branch(4'b1000, 1'b1, 32'h200); step();
        chk("ba_taken", 64'(br_taken), 64'h1);
        chk("ba_pc", 64'(pc_target), 64'h200);
        chk("ba_squash", 64'(squash), 64'h1);
        quiet(); step();
        branch(4'b0000, 1'b0, 32'h250); step();
        chk("bn_taken", 64'(br_taken), 64'h0);
        chk("bn_squash", 64'(squash), 64'h0);
        chk("bn_pc_hold", 64'(pc_target), 64'h200);
        $display("BA,a/BN: pc=%0h", pc_target);

        // Stall holds an accepted taken branch for 3 cycles
        quiet(); branch(4'b1000, 1'b0, 32'h400); step();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; randomize_inputs(); step();
            chk("stall_taken", 64'(br_taken), 64'h1);
            chk("stall_pc", 64'(pc_target), 64'h400);
        end
        $display("stall: taken held=%b pc=%0h", br_taken, pc_target);
        quiet(); step();

        // Reset during DLY_ANNUL returns to IDLE
        branch(4'b1000, 1'b1, 32'h480); step();
        chk("pre_rst_squash", 64'(squash), 64'h1);
        Clr = 1'b0; branch(4'b1000, 1'b0, 32'h4c0); step();
        chk("annul_rst_squash", 64'(squash), 64'h0);
        Clr = 1'b1; branch(4'b1000, 1'b0, 32'h500); step();
        chk("idle_after_rst", 64'(br_taken), 64'h1);
        chk("idle_after_rst_pc", 64'(pc_target), 64'h500);
        $display("reset in DLY_ANNUL: accepted next branch pc=%0h", pc_target);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            Clr   = ($urandom_range(0, 63) != 0);
            stall = ($urandom_range(0, 4) == 0);
            br_valid = ($urandom_range(0, 2) != 0);
            step();
        end
        $display("random: %0d cycles", 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
